peg_l2_rs_rmii_rx: RTL and testbench



---
 rtl/peg_l2_rs_rmii_pkg.sv | 23 ++
 rtl/peg_l2_rs_rmii_rx_sampler.sv | 40 ++++
 rtl/peg_l2_rs_rmii_rx.sv | 179 +++++++++++++++++
 tb/tb_peg_l2_rs_rmii_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/peg_l2_rs_rmii_pkg.sv
// Shared types and constants for the RMII receive reconciliation sublayer.
package peg_l2_rs_rmii_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } rx_state_e;

  localparam logic [1:0] PREAMBLE_DIBIT   = 2'b01;
  localparam logic [1:0] SFD_DIBIT        = 2'b11;
  localparam int         SAMPLE_POINT_10M = 4;
  localparam int         BYTE_W           = 8;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [BYTE_W-1:0] data;
    logic              err;
  } rx_beat_t;

endpackage

// File: rtl/peg_l2_rs_rmii_rx_sampler.sv
// Dibit sample strobe: every cycle at 100 Mb/s, mid-dibit of each DECIM_10M-cycle
// dibit at 10 Mb/s, phase-locked to the rising edge of crs_dv out of IDLE.
module peg_l2_rs_rmii_rx_sampler
  import peg_l2_rs_rmii_pkg::*;
#(
  parameter int DECIM_10M = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic speed,
  input  logic crs_dv,
  input  logic idle,
  output logic sample_strobe
);

  localparam int CNT_W = $clog2(DECIM_10M);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (speed || (idle && !crs_dv)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DECIM_10M - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign sample_strobe = speed | (cnt_q == CNT_W'(SAMPLE_POINT_10M));

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/peg_l2_rs_rmii_rx.sv
// RMII RX reconciliation: strips preamble/SFD and emits an LSB-first byte stream
// with sop/eop/error framing. Optional stats counters under PEG_L2_RS_RMII_RX_STATS_EN.
module peg_l2_rs_rmii_rx
  import peg_l2_rs_rmii_pkg::*;
#(
  parameter int PKT_DATA_W = 8,
  parameter int DECIM_10M  = 10
) (
  input  logic                  rmii_ref_clk,
  input  logic                  rst,
  input  logic                  config_rs_mii_speed_100_n_10,
  input  logic [1:0]            rmii_rxd,
  input  logic                  rmii_crs_dv,
  input  logic                  rmii_rx_er,
  output logic                  pkt_valid,
  output logic                  pkt_sop,
  output logic                  pkt_eop,
  output logic [PKT_DATA_W-1:0] pkt_data,
  output logic                  pkt_error
`ifdef PEG_L2_RS_RMII_RX_STATS_EN
  ,
  output logic [15:0]           stat_frame_ok_cnt,
  output logic [15:0]           stat_frame_err_cnt
`endif
);

  rx_state_e         state_q, state_d;
  logic              speed_q, speed_d;
  logic [1:0]        dibit_idx_q, dibit_idx_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] held_q, held_d;
  logic              held_vld_q, held_vld_d;
  logic              first_q, first_d;
  logic              err_flag_q, err_flag_d;
  logic              valid_q, valid_d;
  rx_beat_t          beat_q, beat_d;
  logic              sample_strobe;

  peg_l2_rs_rmii_rx_sampler #(
    .DECIM_10M (DECIM_10M)
  ) u_sampler (
    .clk           (rmii_ref_clk),
    .rst           (rst),
    .speed         (speed_q),
    .crs_dv        (rmii_crs_dv),
    .idle          (state_q == IDLE),
    .sample_strobe (sample_strobe)
  );

  always_comb begin
    state_d     = state_q;
    speed_d     = (state_q == IDLE) ? config_rs_mii_speed_100_n_10 : speed_q;
    dibit_idx_d = dibit_idx_q;
    shift_d     = shift_q;
    held_d      = held_q;
    held_vld_d  = held_vld_q;
    first_d     = first_q;
    err_flag_d  = err_flag_q;
    valid_d     = 1'b0;
    beat_d      = '0;

    if (sample_strobe) begin
      unique case (state_q)
        IDLE: begin
          if (rmii_crs_dv && rmii_rxd == PREAMBLE_DIBIT) state_d = PREAMBLE;
        end
        PREAMBLE: begin
          if (!rmii_crs_dv) begin
            state_d = IDLE;
          end else if (rmii_rxd == SFD_DIBIT) begin
            state_d     = DATA;
            dibit_idx_d = '0;
            err_flag_d  = 1'b0;
            held_vld_d  = 1'b0;
            shift_d     = '0;
          end else if (rmii_rxd != PREAMBLE_DIBIT) begin
            state_d = DROP;
          end
        end
        DATA: begin
          if (rmii_crs_dv) begin
            shift_d[{dibit_idx_q, 1'b0} +: 2] = rmii_rxd;
            dibit_idx_d = dibit_idx_q + 2'd1;
            err_flag_d  = err_flag_q | rmii_rx_er;
            // A byte is held one byte-time so the last one can carry eop.
            if (dibit_idx_q == 2'd3) begin
              held_d     = shift_d;
              held_vld_d = 1'b1;
              first_d    = !held_vld_q;
              if (held_vld_q) begin
                valid_d     = 1'b1;
                beat_d.sop  = first_q;
                beat_d.data = held_q;
              end
            end
          end else begin
            state_d     = IDLE;
            held_vld_d  = 1'b0;
            dibit_idx_d = '0;
            if (held_vld_q) begin
              valid_d     = 1'b1;
              beat_d.sop  = first_q;
              beat_d.eop  = 1'b1;
              beat_d.data = held_q;
              beat_d.err  = err_flag_q | (dibit_idx_q != 2'd0);
            end
          end
        end
        DROP: begin
          if (!rmii_crs_dv) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge rmii_ref_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      speed_q     <= 1'b0;
      dibit_idx_q <= '0;
      shift_q     <= '0;
      held_q      <= '0;
      held_vld_q  <= 1'b0;
      first_q     <= 1'b0;
      err_flag_q  <= 1'b0;
      valid_q     <= 1'b0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      speed_q     <= speed_d;
      dibit_idx_q <= dibit_idx_d;
      shift_q     <= shift_d;
      held_q      <= held_d;
      held_vld_q  <= held_vld_d;
      first_q     <= first_d;
      err_flag_q  <= err_flag_d;
      valid_q     <= valid_d;
      beat_q      <= beat_d;
    end
  end

  assign pkt_valid = valid_q;
  assign pkt_sop   = beat_q.sop;
  assign pkt_eop   = beat_q.eop;
  assign pkt_data  = beat_q.data;
  assign pkt_error = beat_q.err;

`ifdef PEG_L2_RS_RMII_RX_STATS_EN
  logic        frame_ok, frame_bad;
  logic [15:0] ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;

  // Bad frames: errored eop, runt after SFD, and false-carrier entry into DROP.
  always_comb begin
    frame_ok  = valid_d & beat_d.eop & ~beat_d.err;
    frame_bad = (valid_d & beat_d.eop & beat_d.err)
              | (state_q == PREAMBLE && state_d == DROP)
              | (state_q == DATA && state_d == IDLE && !held_vld_q);
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    if (frame_ok  && ok_cnt_q  != 16'hFFFF) ok_cnt_d  = ok_cnt_q + 16'd1;
    if (frame_bad && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge rmii_ref_clk) begin
    if (rst) begin
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign stat_frame_ok_cnt  = ok_cnt_q;
  assign stat_frame_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_peg_l2_rs_rmii_rx.sv
// Self-checking bench for peg_l2_rs_rmii_rx: frame table plus hand-written corner cases,
// with a scoreboard queue of expected output beats.
module tb_peg_l2_rs_rmii_rx;

  localparam int DECIM = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       speed;
  logic [1:0] rxd;
  logic       crs_dv;
  logic       rx_er;
  logic       pkt_valid, pkt_sop, pkt_eop, pkt_error;
  logic [7:0] pkt_data;
`ifdef PEG_L2_RS_RMII_RX_STATS_EN
  logic [15:0] stat_ok, stat_err;
`endif

  always #10 clk = ~clk;

  peg_l2_rs_rmii_rx #(.PKT_DATA_W(8), .DECIM_10M(DECIM)) dut (
    .rmii_ref_clk                 (clk),
    .rst                          (rst),
    .config_rs_mii_speed_100_n_10 (speed),
    .rmii_rxd                     (rxd),
    .rmii_crs_dv                  (crs_dv),
    .rmii_rx_er                   (rx_er),
    .pkt_valid                    (pkt_valid),
    .pkt_sop                      (pkt_sop),
    .pkt_eop                      (pkt_eop),
    .pkt_data                     (pkt_data),
    .pkt_error                    (pkt_error)
`ifdef PEG_L2_RS_RMII_RX_STATS_EN
    ,
    .stat_frame_ok_cnt            (stat_ok),
    .stat_frame_err_cnt           (stat_err)
`endif
  );

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
    logic       err;
  } beat_t;

  // One received frame: speed, full bytes, optional rx_er byte, trailing dibits,
  // and the expected pkt_error on its eop beat.
  typedef struct {
    logic            spd;
    int              n;
    logic [0:3][7:0] b;
    int              er_byte;
    int              tail;
    logic            exp_eop_err;
  } vec_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    hold   = 1;
  int    exp_ok = 0;
  int    exp_err = 0;
  logic  prev_valid = 1'b0;
  beat_t mon_got, mon_exp;
  vec_t  vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && pkt_valid) begin
      if (hold > 1) check("spacing_10m", 32'(prev_valid), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(pkt_valid), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_got = {pkt_sop, pkt_eop, pkt_data, pkt_error};
        check("beat{sop,eop,data,err}", 32'(mon_got), 32'(mon_exp));
      end
    end
    prev_valid = pkt_valid;
  end

  task automatic dibit(input logic [1:0] d, input logic dv, input logic er);
    rxd    = d;
    crs_dv = dv;
    rx_er  = er;
    repeat (hold) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic er);
    for (int i = 0; i < 4; i++) dibit(b[2*i +: 2], 1'b1, er && (i == 1));
  endtask

  task automatic preamble_sfd();
    for (int i = 0; i < 31; i++) dibit(2'b01, 1'b1, 1'b0);
    dibit(2'b11, 1'b1, 1'b0);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) dibit(2'b00, 1'b0, 1'b0);
  endtask

  task automatic set_speed(input logic s);
    speed = s;
    hold  = s ? 1 : DECIM;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] tail_byte;
    tail_byte = 8'hC6;
    set_speed(v.spd);
    for (int i = 0; i < v.n; i++)
      exp_q.push_back('{sop: (i == 0), eop: (i == v.n - 1), data: v.b[i],
                        err: (i == v.n - 1) ? v.exp_eop_err : 1'b0});
    if (v.n == 0)            exp_err++;
    else if (v.exp_eop_err)  exp_err++;
    else                     exp_ok++;
    preamble_sfd();
    for (int i = 0; i < v.n; i++) send_byte(v.b[i], i == v.er_byte);
    for (int t = 0; t < v.tail; t++) dibit(tail_byte[2*t +: 2], 1'b1, 1'b0);
    gap(8);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 3, {8'h01, 8'hAB, 8'hFF, 8'h00}, -1, 0, 1'b0};
    vecs[1] = '{1'b0, 3, {8'h01, 8'hAB, 8'hFF, 8'h00}, -1, 0, 1'b0};
    vecs[2] = '{1'b1, 3, {8'h10, 8'h20, 8'h30, 8'h00},  1, 0, 1'b1};
    vecs[3] = '{1'b1, 3, {8'h11, 8'h22, 8'h33, 8'h00}, -1, 2, 1'b1};
    vecs[4] = '{1'b0, 1, {8'h5A, 8'h00, 8'h00, 8'h00}, -1, 0, 1'b0};
    vecs[5] = '{1'b0, 3, {8'hC3, 8'h3C, 8'h99, 8'h00},  1, 0, 1'b1};
    vecs[6] = '{1'b1, 1, {8'h5A, 8'h00, 8'h00, 8'h00}, -1, 0, 1'b0};
    vecs[7] = '{1'b0, 2, {8'hA5, 8'h0F, 8'h00, 8'h00}, -1, 1, 1'b1};

    rst = 1'b1; speed = 1'b1; rxd = 2'b00; crs_dv = 1'b0; rx_er = 1'b0; hold = 1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({pkt_valid, pkt_sop, pkt_eop, pkt_error, pkt_data}), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // False carrier: bad dibit in preamble, junk until carrier drops, then a good frame.
    set_speed(1'b1);
    for (int i = 0; i < 4; i++) dibit(2'b01, 1'b1, 1'b0);
    dibit(2'b10, 1'b1, 1'b0);
    dibit(2'b01, 1'b1, 1'b0);
    dibit(2'b11, 1'b1, 1'b0);
    dibit(2'b00, 1'b1, 1'b0);
    dibit(2'b01, 1'b1, 1'b0);
    gap(8);
    exp_err++;
    check("false_carrier_silent", 32'(exp_q.size()), 32'd0);
    run_vec(vecs[0]);

    // Runt: SFD immediately followed by loss of carrier, in both speeds.
    for (int s = 0; s < 2; s++) begin
      set_speed(s[0]);
      preamble_sfd();
      gap(8);
      exp_err++;
      check("runt_silent", 32'(exp_q.size()), 32'd0);
    end

    // Reset mid-frame: first byte already emitted, no eop may follow.
    set_speed(1'b1);
    exp_q.push_back('{sop: 1'b1, eop: 1'b0, data: 8'h12, err: 1'b0});
    preamble_sfd();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    dibit(2'b10, 1'b1, 1'b0);
    dibit(2'b01, 1'b1, 1'b0);
    rst = 1'b1; crs_dv = 1'b0; rxd = 2'b00;
    repeat (2) @(negedge clk);
    check("midframe_reset_outputs",
          32'({pkt_valid, pkt_sop, pkt_eop, pkt_error, pkt_data}), 32'd0);
    rst = 1'b0;
    exp_ok = 0; exp_err = 0;
    gap(8);
    check("midframe_reset_drain", 32'(exp_q.size()), 32'd0);
    run_vec(vecs[6]);

`ifdef PEG_L2_RS_RMII_RX_STATS_EN
    check("stat_ok",  32'(stat_ok),  32'(exp_ok));
    check("stat_err", 32'(stat_err), 32'(exp_err));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
